// File: rtl/colour_pkg.sv
// Shared types for the colour sequencer: FSM states,
// 3-bit colour codes and the 001..110 colour ring.
package colour_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVR   = 2'd3
  } state_t;

  localparam logic [2:0] C_BLACK   = 3'b000;
  localparam logic [2:0] C_BLUE    = 3'b001;
  localparam logic [2:0] C_GREEN   = 3'b010;
  localparam logic [2:0] C_CYAN    = 3'b011;
  localparam logic [2:0] C_RED     = 3'b100;
  localparam logic [2:0] C_MAGENTA = 3'b101;
  localparam logic [2:0] C_YELLOW  = 3'b110;
  localparam logic [2:0] C_WHITE   = 3'b111;

  // Black and white are outside the ring; they map back to its start.
  function automatic logic [2:0] next_colour(
    input logic [2:0] c
  );
    logic [2:0] n;
    case (c)
      C_BLUE:    n = C_GREEN;
      C_GREEN:   n = C_CYAN;
      C_CYAN:    n = C_RED;
      C_RED:     n = C_MAGENTA;
      C_MAGENTA: n = C_YELLOW;
      default:   n = C_BLUE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/colour_sequencer_dwell_timer.sv
// Dwell timer: programmable dwell register and cycle counter.
// Ports: clear/enable drive cnt, load captures dwell, expire flags end of dwell.
module dwell_timer #(
  parameter int unsigned DWELL_W = 8,
  parameter logic [DWELL_W-1:0] DEFAULT_DWELL = 8'd10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               enable,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic               expire
);

  logic [DWELL_W-1:0] dwell_reg;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] last;

  // A dwell of zero behaves as one cycle per colour.
  assign last = (dwell_reg == '0) ? '0 : dwell_reg - 1'b1;
  // >= so a dwell shortened below cnt expires at once.
  assign expire = (cnt >= last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_reg <= DEFAULT_DWELL;
    end else if (load) begin
      dwell_reg <= dwell;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/colour_sequencer.sv
// Colour sequencer: steps the RGB converter through six colours
// with run/pause/step control and a request/grant override port.
module colour_sequencer
  import colour_pkg::*;
#(
  parameter int unsigned DWELL_W = 8,
  parameter logic [DWELL_W-1:0] DEFAULT_DWELL = 8'd10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               dwell_load,
  input  logic               ovr_req,
  input  logic [2:0]         ovr_colour,
  output logic               ovr_gnt,
  output logic               conv_enable,
  output logic [2:0]         conv_colour,
  output logic               wrap,
  output logic               busy
);

  state_t     state_q, state_n;
  state_t     sv_state_q, sv_state_n;
  logic [2:0] col_q, col_n;
  logic [2:0] sv_col_q, sv_col_n;
  logic       clr, inc, expire, wrap_n;

  dwell_timer #(
    .DWELL_W      (DWELL_W),
    .DEFAULT_DWELL(DEFAULT_DWELL)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clr),
    .enable(inc),
    .load  (dwell_load),
    .dwell (dwell),
    .expire(expire)
  );

  always_comb begin
    state_n    = state_q;
    col_n      = col_q;
    sv_state_n = sv_state_q;
    sv_col_n   = sv_col_q;
    clr        = 1'b0;
    inc        = 1'b0;
    wrap_n     = 1'b0;
    if (ovr_req && state_q != OVR) begin
      state_n    = OVR;
      sv_state_n = state_q;
      sv_col_n   = col_q;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_n = RUN;
            col_n   = C_BLUE;
            clr     = 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_n = PAUSE;
          end else if (expire) begin
            col_n  = next_colour(col_q);
            clr    = 1'b1;
            wrap_n = (col_q == C_YELLOW);
          end else begin
            inc = 1'b1;
          end
        end
        PAUSE: begin
          if (stop) begin
            state_n = IDLE;
            col_n   = C_BLACK;
          end else if (start) begin
            state_n = RUN;
            clr     = 1'b1;
          end else if (step) begin
            col_n  = next_colour(col_q);
            clr    = 1'b1;
            wrap_n = (col_q == C_YELLOW);
          end
        end
        OVR: begin
          if (!ovr_req) begin
            state_n = sv_state_q;
            col_n   = sv_col_q;
            clr     = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= C_BLACK;
      sv_state_q  <= IDLE;
      sv_col_q    <= C_BLACK;
      ovr_gnt     <= 1'b0;
      conv_enable <= 1'b0;
      conv_colour <= C_BLACK;
      wrap        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_n;
      col_q       <= col_n;
      sv_state_q  <= sv_state_n;
      sv_col_q    <= sv_col_n;
      ovr_gnt     <= (state_n == OVR);
      conv_enable <= (state_n != IDLE);
      conv_colour <= (state_n == OVR) ? ovr_colour : col_n;
      wrap        <= wrap_n;
      busy        <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_colour_sequencer.sv
// Directed bench for colour_sequencer.
// Hand-computed expectations checked with immediate assertions.
module tb_colour_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, step;
  logic [7:0] dwell;
  logic       dwell_load;
  logic       ovr_req;
  logic [2:0] ovr_colour;
  logic       ovr_gnt, conv_enable, wrap, busy;
  logic [2:0] conv_colour;

  int tests = 0;
  int fails = 0;

  colour_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .step       (step),
    .dwell      (dwell),
    .dwell_load (dwell_load),
    .ovr_req    (ovr_req),
    .ovr_colour (ovr_colour),
    .ovr_gnt    (ovr_gnt),
    .conv_enable(conv_enable),
    .conv_colour(conv_colour),
    .wrap       (wrap),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic en,
                         input logic [2:0] col,
                         input logic bsy);
    chk({tag, ".en"}, 32'(conv_enable), 32'(en));
    chk({tag, ".col"}, 32'(conv_colour), 32'(col));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
  endtask

  logic [2:0] ring [6];

  initial begin
    ring[0] = 3'b001; ring[1] = 3'b010;
    ring[2] = 3'b011; ring[3] = 3'b100;
    ring[4] = 3'b101; ring[5] = 3'b110;
    rst_n = 1'b0;
    start = 0; stop = 0; step = 0;
    dwell = 8'd0; dwell_load = 0;
    ovr_req = 0; ovr_colour = 3'b000;

    // reset
    repeat (3) tick();
    chk_out("rst", 1'b0, 3'b000, 1'b0);
    chk("rst.gnt", 32'(ovr_gnt), 0);
    chk("rst.wrap", 32'(wrap), 0);
    rst_n = 1'b1;
    tick();
    chk_out("idle", 1'b0, 3'b000, 1'b0);

    // step ignored in IDLE
    step = 1; tick(); step = 0;
    chk_out("idle.step", 1'b0, 3'b000, 1'b0);

    // dwell=3 then start
    dwell = 8'd3; dwell_load = 1; tick(); dwell_load = 0;
    start = 1; tick(); start = 0;
    chk_out("start", 1'b1, 3'b001, 1'b1);
    chk("start.wrap", 32'(wrap), 0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("run.col", 32'(conv_colour), 32'(ring[(k / 3) % 6]));
      chk("run.wrap", 32'(wrap), 32'(k == 18));
    end

    // reach 011 (k=24) then pause
    repeat (4) tick();
    chk("pre_pause.col", 32'(conv_colour), 32'(3'b011));
    stop = 1; tick(); stop = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out("pause.hold", 1'b1, 3'b011, 1'b1);
    end
    step = 1; tick(); step = 0;
    chk("step1.col", 32'(conv_colour), 32'(3'b100));
    tick();
    chk("step1.hold", 32'(conv_colour), 32'(3'b100));
    step = 1; tick(); step = 0;
    chk("step2.col", 32'(conv_colour), 32'(3'b101));
    stop = 1; tick(); stop = 0;
    chk_out("pause.stop", 1'b0, 3'b000, 1'b0);

    // override at 010
    start = 1; tick(); start = 0;
    repeat (3) tick();
    chk("pre_ovr.col", 32'(conv_colour), 32'(3'b010));
    ovr_req = 1; ovr_colour = 3'b111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ovr.gnt", 32'(ovr_gnt), 1);
      chk_out("ovr", 1'b1, 3'b111, 1'b1);
      chk("ovr.wrap", 32'(wrap), 0);
    end
    ovr_req = 0;
    tick();
    chk("ovr_end.gnt", 32'(ovr_gnt), 0);
    chk_out("ovr_end", 1'b1, 3'b010, 1'b1);
    tick();
    chk("ovr_dw1", 32'(conv_colour), 32'(3'b010));
    tick();
    chk("ovr_dw2", 32'(conv_colour), 32'(3'b010));
    tick();
    chk("ovr_dw3", 32'(conv_colour), 32'(3'b011));

    // dwell=0: advance every cycle
    dwell = 8'd0; dwell_load = 1; tick(); dwell_load = 0;
    chk("d0.load", 32'(conv_colour), 32'(3'b011));
    tick(); chk("d0.a", 32'(conv_colour), 32'(3'b100));
    tick(); chk("d0.b", 32'(conv_colour), 32'(3'b101));
    tick(); chk("d0.c", 32'(conv_colour), 32'(3'b110));
    chk("d0.c.wrap", 32'(wrap), 0);
    tick(); chk("d0.d", 32'(conv_colour), 32'(3'b001));
    chk("d0.d.wrap", 32'(wrap), 1);

    // dwell 10 -> 2 at cnt=6
    dwell = 8'd10; dwell_load = 1; tick(); dwell_load = 0;
    chk("d10.col", 32'(conv_colour), 32'(3'b010));
    chk("d10.wrap", 32'(wrap), 0);
    repeat (6) tick();
    chk("d10.cnt6", 32'(conv_colour), 32'(3'b010));
    dwell = 8'd2; dwell_load = 1; tick(); dwell_load = 0;
    chk("d2.load", 32'(conv_colour), 32'(3'b010));
    tick();
    chk("d2.adv", 32'(conv_colour), 32'(3'b011));

    // stop+start in RUN -> PAUSE
    stop = 1; start = 1; tick(); stop = 0; start = 0;
    repeat (3) tick();
    chk_out("ss.pause", 1'b1, 3'b011, 1'b1);
    start = 1; tick(); start = 0;
    tick();
    chk("resume.a", 32'(conv_colour), 32'(3'b011));
    tick();
    chk("resume.b", 32'(conv_colour), 32'(3'b100));
    repeat (2) tick();
    chk("pre_rst.col", 32'(conv_colour), 32'(3'b101));

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk_out("arst", 1'b0, 3'b000, 1'b0);
    chk("arst.gnt", 32'(ovr_gnt), 0);
    tick();
    #2 rst_n = 1'b1;
    repeat (3) tick();
    chk_out("arst.idle", 1'b0, 3'b000, 1'b0);
    start = 1; tick(); start = 0;
    chk_out("arst.start", 1'b1, 3'b001, 1'b1);
    // default dwell of 10 restored
    repeat (9) tick();
    chk("dflt.9", 32'(conv_colour), 32'(3'b001));
    tick();
    chk("dflt.10", 32'(conv_colour), 32'(3'b010));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
